uart_cmd_ctrl: RTL and testbench

//   Parametrised UART command controller, successor to the fixed banner/wait top-level FSM.

---
 rtl/uart_cmd_pkg.sv | 47 ++++
 rtl/uart_cmd_ctrl_if.sv | 35 +++
 rtl/cmd_line_parser.sv | 88 ++++++++
 rtl/uart_cmd_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared encodings for the UART command controller: FSM states,
//               printer string IDs, executor command IDs and ASCII constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_BANNER    = 3'd0,
        ST_IDLE      = 3'd1,
        ST_DISPATCH  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_REPLY     = 3'd4
    } state_e;

    localparam int unsigned STR_BANNER   = 0;
    localparam int unsigned STR_OK       = 1;
    localparam int unsigned STR_ERR_UNK  = 2;
    localparam int unsigned STR_ERR_OVF  = 3;
    localparam int unsigned STR_ERR_ARG  = 4;
    localparam int unsigned STR_HELP     = 5;
    localparam int unsigned STR_ERR_TMO  = 6;
    localparam int unsigned STR_ERR_EXEC = 7;

    localparam logic [1:0] CMD_LED    = 2'd0;
    localparam logic [1:0] CMD_STATUS = 2'd1;
    localparam logic [1:0] CMD_RESET  = 2'd2;

    localparam logic [7:0] ASC_L  = 8'h4C;
    localparam logic [7:0] ASC_S  = 8'h53;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_H  = 8'h48;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl_if
// Description : RX byte stream, printer and executor handshakes of the UART
//               command controller. master = controller, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if #(
    parameter int unsigned ARG_W    = 16,
    parameter int unsigned STR_ID_W = 3
);
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic [STR_ID_W-1:0] printer_str_id;
    logic                printer_enable;
    logic                printer_done;
    logic                cmd_valid;
    logic [1:0]          cmd_id;
    logic [ARG_W-1:0]    cmd_arg;
    logic                cmd_ready;
    logic                cmd_done;
    logic                cmd_err;
    logic [7:0]          rx_drop_cnt;

    modport master (
        input  rx_valid, rx_data, printer_done, cmd_ready, cmd_done, cmd_err,
        output printer_str_id, printer_enable, cmd_valid, cmd_id, cmd_arg, rx_drop_cnt
    );

    modport slave (
        output rx_valid, rx_data, printer_done, cmd_ready, cmd_done, cmd_err,
        input  printer_str_id, printer_enable, cmd_valid, cmd_id, cmd_arg, rx_drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cmd_line_parser.sv
`default_nettype none
// ============================================================================
// Module      : cmd_line_parser
// Description : Accumulates one command line: opcode, length, decimal
//               argument and the sticky overflow / argument-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_line_parser
    import uart_cmd_pkg::*;
#(
    parameter  int unsigned CMD_MAX_LEN = 8,
    parameter  int unsigned ARG_W       = 16,
    localparam int unsigned LEN_W       = $clog2(CMD_MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             char_valid_i,
    input  logic [7:0]       char_i,
    output logic [7:0]       opcode_o,
    output logic [LEN_W-1:0] len_o,
    output logic [ARG_W-1:0] arg_o,
    output logic             ovf_o,
    output logic             arg_err_o
);
    logic [7:0]       opcode_q, opcode_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic             ovf_q, ovf_d;
    logic             arg_err_q, arg_err_d;
    logic [ARG_W+3:0] w_arg_ext, w_arg_next;

    // Four guard bits are enough to hold arg*10+9 and expose overflow.
    assign w_arg_ext  = {4'b0000, arg_q};
    assign w_arg_next = (w_arg_ext << 3) + (w_arg_ext << 1) + {{ARG_W{1'b0}}, char_i[3:0]};

    always_comb begin
        opcode_d  = opcode_q;
        len_d     = len_q;
        arg_d     = arg_q;
        ovf_d     = ovf_q;
        arg_err_d = arg_err_q;
        if (clr_i) begin
            opcode_d  = '0;
            len_d     = '0;
            arg_d     = '0;
            ovf_d     = 1'b0;
            arg_err_d = 1'b0;
        end else if (char_valid_i) begin
            if (len_q == LEN_W'(CMD_MAX_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                len_d = len_q + LEN_W'(1);
                if (len_q == '0) begin
                    opcode_d = to_upper(char_i);
                end else if (!is_digit(char_i) || (w_arg_next[ARG_W+3:ARG_W] != 4'd0)) begin
                    arg_err_d = 1'b1;
                end else if (!arg_err_q) begin
                    arg_d = w_arg_next[ARG_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            len_q     <= '0;
            arg_q     <= '0;
            ovf_q     <= 1'b0;
            arg_err_q <= 1'b0;
        end else begin
            opcode_q  <= opcode_d;
            len_q     <= len_d;
            arg_q     <= arg_d;
            ovf_q     <= ovf_d;
            arg_err_q <= arg_err_d;
        end
    end

    assign opcode_o  = opcode_q;
    assign len_o     = len_q;
    assign arg_o     = arg_q;
    assign ovf_o     = ovf_q;
    assign arg_err_o = arg_err_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : UART command controller: banner, CR/LF line assembly, command
//               dispatch to an executor and result reporting via the printer.
//               Define CMD_TIMEOUT_EN to discard stale partial lines.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned BANNER_PERIOD = 135_000_000,
    parameter int unsigned CMD_MAX_LEN   = 8,
    parameter int unsigned ARG_W         = 16,
    parameter int unsigned STR_ID_W      = 3,
    parameter int unsigned TIMEOUT_CYC   = 27_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_ctrl_if.master  bus
);
    localparam int unsigned LEN_W = $clog2(CMD_MAX_LEN + 1);
    localparam int unsigned BNR_W = (BANNER_PERIOD > 1) ? $clog2(BANNER_PERIOD) : 1;
`ifdef CMD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic                pr_en_q, pr_en_d;
    logic [STR_ID_W-1:0] str_id_q, str_id_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_id_q, cmd_id_d;
    logic [ARG_W-1:0]    cmd_arg_q, cmd_arg_d;
    logic [7:0]          drop_q, drop_d;

    logic [7:0]       w_opcode;
    logic [LEN_W-1:0] w_len;
    logic [ARG_W-1:0] w_arg;
    logic             w_ovf, w_arg_err, w_is_term, w_quiet_idle, w_banner_hit, w_tmo_hit;

    assign w_is_term    = (bus.rx_data == ASC_CR) || (bus.rx_data == ASC_LF);
    assign w_quiet_idle = (state_q == ST_IDLE) && !bus.rx_valid;

    // Line state is held cleared outside IDLE, so each new line starts empty.
    cmd_line_parser #(
        .CMD_MAX_LEN (CMD_MAX_LEN),
        .ARG_W       (ARG_W)
    ) u_parser (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (state_q != ST_IDLE),
        .char_valid_i ((state_q == ST_IDLE) && bus.rx_valid && !w_is_term),
        .char_i       (bus.rx_data),
        .opcode_o     (w_opcode),
        .len_o        (w_len),
        .arg_o        (w_arg),
        .ovf_o        (w_ovf),
        .arg_err_o    (w_arg_err)
    );

    if (BANNER_PERIOD != 0) begin : g_banner
        logic [BNR_W-1:0] bnr_cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bnr_cnt_q <= '0;
            end else if ((state_q != ST_IDLE) || bus.rx_valid || (w_len != '0) || w_banner_hit) begin
                bnr_cnt_q <= '0;
            end else begin
                bnr_cnt_q <= bnr_cnt_q + BNR_W'(1);
            end
        end
        assign w_banner_hit = w_quiet_idle && (w_len == '0) && (bnr_cnt_q == BNR_W'(BANNER_PERIOD - 1));
    end else begin : g_no_banner
        assign w_banner_hit = 1'b0;
    end

    if (TMO_EN) begin : g_tmo
        localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
        logic [TMO_W-1:0] tmo_cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tmo_cnt_q <= '0;
            end else if ((state_q != ST_IDLE) || bus.rx_valid || (w_len == '0) || w_tmo_hit) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
        assign w_tmo_hit = w_quiet_idle && (w_len != '0) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_tmo
        assign w_tmo_hit = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        pr_en_d     = pr_en_q;
        str_id_d    = str_id_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        cmd_arg_d   = cmd_arg_q;
        drop_d      = drop_q;
        if (bus.rx_valid && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        case (state_q)
            ST_BANNER, ST_REPLY: begin
                // Request stays up until done; done only counts while requesting.
                if (pr_en_q && bus.printer_done) begin
                    pr_en_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    pr_en_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.rx_valid && w_is_term && (w_len != '0)) begin
                    state_d = ST_REPLY;
                    pr_en_d = 1'b1;
                    if (w_ovf) begin
                        str_id_d = STR_ID_W'(STR_ERR_OVF);
                    end else if (w_arg_err) begin
                        str_id_d = STR_ID_W'(STR_ERR_ARG);
                    end else if (w_opcode == ASC_H) begin
                        str_id_d = STR_ID_W'(STR_HELP);
                    end else if ((w_opcode == ASC_L) || (w_opcode == ASC_S) || (w_opcode == ASC_R)) begin
                        state_d     = ST_DISPATCH;
                        pr_en_d     = 1'b0;
                        cmd_valid_d = 1'b1;
                        cmd_arg_d   = w_arg;
                        cmd_id_d    = (w_opcode == ASC_L) ? CMD_LED :
                                      (w_opcode == ASC_S) ? CMD_STATUS : CMD_RESET;
                    end else begin
                        str_id_d = STR_ID_W'(STR_ERR_UNK);
                    end
                end else if (w_tmo_hit) begin
                    state_d  = ST_REPLY;
                    pr_en_d  = 1'b1;
                    str_id_d = STR_ID_W'(STR_ERR_TMO);
                end else if (w_banner_hit) begin
                    state_d  = ST_BANNER;
                    pr_en_d  = 1'b1;
                    str_id_d = STR_ID_W'(STR_BANNER);
                end
            end
            ST_DISPATCH: begin
                if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.cmd_done) begin
                    state_d  = ST_REPLY;
                    pr_en_d  = 1'b1;
                    str_id_d = bus.cmd_err ? STR_ID_W'(STR_ERR_EXEC) : STR_ID_W'(STR_OK);
                end
            end
            default: begin
                state_d = ST_BANNER;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BANNER;
            pr_en_q     <= 1'b0;
            str_id_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_arg_q   <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            pr_en_q     <= pr_en_d;
            str_id_q    <= str_id_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_arg_q   <= cmd_arg_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.printer_enable = pr_en_q;
    assign bus.printer_str_id = str_id_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.cmd_id         = cmd_id_q;
    assign bus.cmd_arg        = cmd_arg_q;
    assign bus.rx_drop_cnt    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Scoreboard bench for uart_cmd_ctrl with printer and executor
//               responders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    localparam int unsigned BANNER_PERIOD = 400;
    localparam int unsigned CMD_MAX_LEN   = 8;
    localparam int unsigned ARG_W         = 16;
    localparam int unsigned STR_ID_W      = 3;
    localparam int unsigned TIMEOUT_CYC   = 100;

    typedef struct {
        logic [1:0]       id;
        logic [ARG_W-1:0] arg;
        bit               err;
        int               dly;
    } exp_cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.ARG_W(ARG_W), .STR_ID_W(STR_ID_W)) bus ();

    uart_cmd_ctrl #(
        .BANNER_PERIOD (BANNER_PERIOD),
        .CMD_MAX_LEN   (CMD_MAX_LEN),
        .ARG_W         (ARG_W),
        .STR_ID_W      (STR_ID_W),
        .TIMEOUT_CYC   (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int       str_q[$];
    exp_cmd_t cmd_q[$];
    int       n_vec    = 0;
    int       n_err    = 0;
    int       pr_dly   = 2;
    int       exp_drop = 0;
    int       rst_cnt  = 0;
    bit       pr_busy  = 1'b0;
    bit       cmd_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_line(input string body, input logic [7:0] term);
        for (int i = 0; i < body.len(); i++) send_byte(body[i]);
        send_byte(term);
    endtask

    task automatic push_cmd(input logic [1:0] id, input int arg, input bit err, input int dly);
        exp_cmd_t e;
        e.id  = id;
        e.arg = ARG_W'(arg);
        e.err = err;
        e.dly = dly;
        cmd_q.push_back(e);
        str_q.push_back(err ? int'(STR_ERR_EXEC) : int'(STR_OK));
    endtask

    task automatic wait_idle(input string tag);
        int n     = 0;
        int quiet = 0;
        while ((quiet < 4) && (n < 4000)) begin
            @(negedge clk);
            n++;
            if ((str_q.size() != 0) || (cmd_q.size() != 0) || pr_busy || cmd_busy ||
                bus.printer_enable || bus.cmd_valid) quiet = 0;
            else quiet++;
        end
        check_eq({tag, "_drain"}, str_q.size() + cmd_q.size() + int'(pr_busy) + int'(cmd_busy), 0);
    endtask

    // Printer model: checks each request against the expected string queue.
    initial begin
        int exp_id;
        bus.printer_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.printer_enable) begin
                pr_busy = 1'b1;
                if (str_q.size() == 0) begin
                    check_eq("print_unexpected", str_q.size(), 1);
                    exp_id = int'(bus.printer_str_id);
                end else begin
                    exp_id = str_q.pop_front();
                    check_eq("print_id", bus.printer_str_id, exp_id);
                end
                repeat (pr_dly) @(negedge clk);
                check_eq("print_hold_en", bus.printer_enable, 1);
                check_eq("print_hold_id", bus.printer_str_id, exp_id);
                bus.printer_done = 1'b1;
                @(negedge clk);
                bus.printer_done = 1'b0;
                check_eq("print_en_drop", bus.printer_enable, 0);
                pr_busy = 1'b0;
            end
        end
    end

    // Executor model: checks offered commands and answers with ready/done.
    initial begin
        exp_cmd_t e;
        int       rc;
        bus.cmd_ready = 1'b0;
        bus.cmd_done  = 1'b0;
        bus.cmd_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.cmd_valid) begin
                cmd_busy = 1'b1;
                rc       = rst_cnt;
                if (cmd_q.size() == 0) begin
                    check_eq("cmd_unexpected", cmd_q.size(), 1);
                    e.id = bus.cmd_id; e.arg = bus.cmd_arg; e.err = 1'b0; e.dly = 0;
                end else begin
                    e = cmd_q.pop_front();
                    check_eq("cmd_id", bus.cmd_id, e.id);
                    check_eq("cmd_arg", bus.cmd_arg, e.arg);
                end
                repeat (e.dly) @(negedge clk);
                if (e.dly > 0 && rc == rst_cnt) begin
                    check_eq("cmd_hold_valid", bus.cmd_valid, 1);
                    check_eq("cmd_hold_arg", bus.cmd_arg, e.arg);
                end
                bus.cmd_ready = 1'b1;
                @(negedge clk);
                bus.cmd_ready = 1'b0;
                if (rc == rst_cnt) check_eq("cmd_valid_drop", bus.cmd_valid, 0);
                repeat (2) @(negedge clk);
                bus.cmd_done = 1'b1;
                bus.cmd_err  = e.err;
                @(negedge clk);
                bus.cmd_done = 1'b0;
                bus.cmd_err  = 1'b0;
                cmd_busy = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_en", bus.printer_enable, 0);
        check_eq("rst_valid", bus.cmd_valid, 0);
        check_eq("rst_drop", bus.rx_drop_cnt, 0);
        str_q.push_back(STR_BANNER);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("banner_first_en", bus.printer_enable, 1);
        check_eq("banner_first_id", bus.printer_str_id, STR_BANNER);
        wait_idle("banner");

        // CRLF: the LF lands during DISPATCH and is dropped, one command only.
        push_cmd(CMD_LED, 12, 1'b0, 3);
        send_line("L12", ASC_CR);
        send_byte(ASC_LF);
        exp_drop++;
        wait_idle("led12");
        check_eq("drop_after_crlf", bus.rx_drop_cnt, exp_drop);

        send_byte(ASC_CR);
        send_byte(ASC_LF);
        wait_idle("empty_lines");

        push_cmd(CMD_STATUS, 0, 1'b1, 0);
        send_line("s", ASC_CR);
        wait_idle("status_err");

        str_q.push_back(STR_ERR_OVF);
        send_line("L123456789", ASC_CR);
        wait_idle("ovf");
        str_q.push_back(STR_ERR_OVF);
        send_line("S00000007", ASC_LF);
        wait_idle("ovf_len9");
        push_cmd(CMD_STATUS, 7, 1'b0, 2);
        send_line("S0000007", ASC_CR);
        wait_idle("len8");
        str_q.push_back(STR_ERR_ARG);
        send_line("L7x", ASC_CR);
        wait_idle("arg_char");
        str_q.push_back(STR_ERR_ARG);
        send_line("L70000", ASC_CR);
        wait_idle("arg_big");
        push_cmd(CMD_LED, 65535, 1'b0, 1);
        send_line("l65535", ASC_CR);
        wait_idle("arg_max");

        str_q.push_back(STR_ERR_UNK);
        send_line("Q", ASC_CR);
        wait_idle("unknown");
        str_q.push_back(STR_HELP);
        send_line("h", ASC_LF);
        wait_idle("help");
        push_cmd(CMD_RESET, 0, 1'b0, 0);
        send_line("R", ASC_CR);
        wait_idle("reset_cmd");

        pr_dly = 12;
        str_q.push_back(STR_ERR_UNK);
        send_line("Z", ASC_CR);
        for (int i = 0; i < 3; i++) send_byte(8'h41);
        exp_drop += 3;
        wait_idle("drop3");
        check_eq("drop_reply", bus.rx_drop_cnt, exp_drop);
        pr_dly = 2;

`ifdef CMD_TIMEOUT_EN
        str_q.push_back(STR_ERR_TMO);
        send_line("L", 8'h35);
        repeat (90) @(negedge clk);
        check_eq("tmo_early", bus.printer_enable, 0);
        repeat (60) @(negedge clk);
        wait_idle("timeout");
`else
        for (int i = 0; i < 2; i++) send_byte((i == 0) ? ASC_L : 8'h35);
        repeat (200) @(negedge clk);
        check_eq("partial_quiet", bus.printer_enable, 0);
        push_cmd(CMD_LED, 5, 1'b0, 1);
        send_byte(ASC_CR);
        wait_idle("partial_line");
`endif

        str_q.push_back(STR_BANNER);
        repeat (BANNER_PERIOD - 20) @(negedge clk);
        check_eq("banner_early", bus.printer_enable, 0);
        repeat (60) @(negedge clk);
        wait_idle("banner_reprint");

        pr_dly = 600;
        str_q.push_back(STR_ERR_UNK);
        send_line("?", ASC_CR);
        for (int i = 0; i < 260; i++) send_byte(8'h42);
        exp_drop = (exp_drop + 260 > 255) ? 255 : exp_drop + 260;
        wait_idle("drop_sat");
        check_eq("drop_saturate", bus.rx_drop_cnt, exp_drop);
        pr_dly = 2;

        cmd_q.push_back('{id: CMD_LED, arg: 16'd9, err: 1'b0, dly: 30});
        send_line("L9", ASC_CR);
        repeat (5) @(negedge clk);
        check_eq("dispatch_valid", bus.cmd_valid, 1);
        rst_cnt++;
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_en", bus.printer_enable, 0);
        check_eq("arst_id", bus.printer_str_id, 0);
        check_eq("arst_valid", bus.cmd_valid, 0);
        check_eq("arst_cmd_id", bus.cmd_id, 0);
        check_eq("arst_arg", bus.cmd_arg, 0);
        check_eq("arst_drop", bus.rx_drop_cnt, 0);
        str_q.push_back(STR_BANNER);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_idle("post_reset");
        check_eq("post_reset_drop", bus.rx_drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
